// File: rtl/sddt_host_driver.sv
// sddt_host_driver
//   Host-side driver for the SDDT core AXI-Stream interfaces (axi_aclk domain).
//   A program of 128-bit command words and 512-bit write-data beats is
//   preloaded through the cfg_* write ports. A start pulse streams the program
//   out on M_AXIS_CMD / M_AXIS_WDATA. Returning read beats on S_AXIS_RDATA are
//   captured into a local buffer that can be read back through rb_addr/rb_data.
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     cfg_cmd_*            command buffer write port (ignored while busy)
//     cfg_wd_*             write-data buffer write port (ignored while busy)
//     cfg_num_*            run lengths, latched and clamped to DEPTH on start
//     start                one-cycle run request (ignored while busy)
//     busy, done           run in progress / sticky run-complete flag
//     rd_overflow          sticky: read beat beyond the expected count
//     rd_count             read beats captured this run
//     rb_addr, rb_data     capture-buffer readback, 1-cycle latency
//     M_AXIS_CMD_*         command stream to core
//     M_AXIS_WDATA_*       write-data stream to core
//     S_AXIS_RDATA_*       read-data stream from core (tkeep/tlast ignored)
//     timeout              only with SDDT_HOST_TIMEOUT_EN: sticky watchdog flag
//
//   Optional feature macro: SDDT_HOST_TIMEOUT_EN
//     Adds a watchdog that ends a run after TIMEOUT_CYCLES cycles without any
//     accepted beat on any of the three streams.

// One AXI-Stream master sender: buffer RAM plus a registered output stage.
// tdata is prefetched from the RAM into the output register so a new beat is
// presented on the edge of every transfer and back-to-back beats need no bubble.
module sddt_host_sender #(
  parameter int W     = 128,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          load,
  input  logic [AW:0]   load_cnt,
  input  logic          abort,
  input  logic          tready,
  output logic          tvalid,
  output logic [W-1:0]  tdata,
  output logic          xfer,
  output logic          sent_all
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  cnt_q;
  logic [AW:0]  ptr;
  logic [AW:0]  ptr_nxt;

  assign xfer     = tvalid & tready;
  assign ptr_nxt  = ptr + 1'b1;
  assign sent_all = (ptr >= cnt_q);

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // ptr is the index of the beat currently presented; tvalid/tdata only move
  // on a transfer, so they stay stable while tready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      ptr    <= '0;
      tvalid <= 1'b0;
      tdata  <= '0;
    end else if (load) begin
      cnt_q  <= load_cnt;
      ptr    <= '0;
      tvalid <= (load_cnt != '0);
      tdata  <= mem[0];
    end else if (abort) begin
      tvalid <= 1'b0;
    end else if (xfer) begin
      ptr    <= ptr_nxt;
      tvalid <= (ptr_nxt < cnt_q);
      // Index wraps to 0 on the final beat of a full buffer; tvalid is low then.
      tdata  <= mem[ptr_nxt[AW-1:0]];
    end
  end
endmodule

module sddt_host_driver #(
  parameter int CMD_DEPTH      = 64,
  parameter int WDATA_DEPTH    = 16,
  parameter int RDATA_DEPTH    = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int CAW = $clog2(CMD_DEPTH),
  localparam int WAW = $clog2(WDATA_DEPTH),
  localparam int RAW = $clog2(RDATA_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_cmd_we,
  input  logic [CAW-1:0] cfg_cmd_addr,
  input  logic [127:0]   cfg_cmd_data,
  input  logic           cfg_wd_we,
  input  logic [WAW-1:0] cfg_wd_addr,
  input  logic [511:0]   cfg_wd_data,
  input  logic [CAW:0]   cfg_num_cmd,
  input  logic [WAW:0]   cfg_num_wdata,
  input  logic [RAW:0]   cfg_num_rdata,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           rd_overflow,
  output logic [RAW:0]   rd_count,
`ifdef SDDT_HOST_TIMEOUT_EN
  output logic           timeout,
`endif
  input  logic [RAW-1:0] rb_addr,
  output logic [511:0]   rb_data,
  output logic [127:0]   M_AXIS_CMD_tdata,
  output logic           M_AXIS_CMD_tvalid,
  input  logic           M_AXIS_CMD_tready,
  output logic [511:0]   M_AXIS_WDATA_tdata,
  output logic           M_AXIS_WDATA_tvalid,
  input  logic           M_AXIS_WDATA_tready,
  input  logic [511:0]   S_AXIS_RDATA_tdata,
  input  logic [63:0]    S_AXIS_RDATA_tkeep,
  input  logic           S_AXIS_RDATA_tlast,
  input  logic           S_AXIS_RDATA_tvalid,
  output logic           S_AXIS_RDATA_tready
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CAW:0] CMD_MAX = (CAW+1)'(CMD_DEPTH);
  localparam logic [WAW:0] WD_MAX  = (WAW+1)'(WDATA_DEPTH);
  localparam logic [RAW:0] RD_MAX  = (RAW+1)'(RDATA_DEPTH);

  state_t       state;
  logic [RAW:0] n_rd;
  logic         start_acc;
  logic [CAW:0] n_cmd_ld;
  logic [WAW:0] n_wd_ld;
  logic [RAW:0] n_rd_ld;
  logic         cmd_xfer, wd_xfer, cmd_sent_all, wd_sent_all;
  logic         rd_acc, rd_keep;
  logic         to_fire;
  logic [511:0] capture [RDATA_DEPTH];

  // Core always sends full beats with tlast=1; these carry no information here.
  logic unused_rd_side;
  assign unused_rd_side = ^{S_AXIS_RDATA_tkeep, S_AXIS_RDATA_tlast};

  assign start_acc = start & (state == IDLE);
  assign n_cmd_ld  = (cfg_num_cmd   > CMD_MAX) ? CMD_MAX : cfg_num_cmd;
  assign n_wd_ld   = (cfg_num_wdata > WD_MAX)  ? WD_MAX  : cfg_num_wdata;
  assign n_rd_ld   = (cfg_num_rdata > RD_MAX)  ? RD_MAX  : cfg_num_rdata;

  sddt_host_sender #(.W(128), .DEPTH(CMD_DEPTH)) u_cmd (
    .clk      (clk),
    .rst      (rst),
    .we       (cfg_cmd_we & ~busy),
    .waddr    (cfg_cmd_addr),
    .wdata    (cfg_cmd_data),
    .load     (start_acc),
    .load_cnt (n_cmd_ld),
    .abort    (to_fire),
    .tready   (M_AXIS_CMD_tready),
    .tvalid   (M_AXIS_CMD_tvalid),
    .tdata    (M_AXIS_CMD_tdata),
    .xfer     (cmd_xfer),
    .sent_all (cmd_sent_all)
  );

  sddt_host_sender #(.W(512), .DEPTH(WDATA_DEPTH)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .we       (cfg_wd_we & ~busy),
    .waddr    (cfg_wd_addr),
    .wdata    (cfg_wd_data),
    .load     (start_acc),
    .load_cnt (n_wd_ld),
    .abort    (to_fire),
    .tready   (M_AXIS_WDATA_tready),
    .tvalid   (M_AXIS_WDATA_tvalid),
    .tdata    (M_AXIS_WDATA_tdata),
    .xfer     (wd_xfer),
    .sent_all (wd_sent_all)
  );

  // Receiver is open for the whole run, including RUN, so read data racing
  // ahead of the last command is still captured.
  assign S_AXIS_RDATA_tready = busy;
  assign rd_acc  = S_AXIS_RDATA_tvalid & busy;
  assign rd_keep = (rd_count < n_rd) && (rd_count < RD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_overflow <= 1'b0;
      rd_count    <= '0;
      n_rd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            rd_overflow <= 1'b0;
            rd_count    <= '0;
            n_rd        <= n_rd_ld;
          end
        end
        RUN: begin
          if (cmd_sent_all && wd_sent_all) state <= DRAIN;
        end
        DRAIN: begin
          if (rd_count >= n_rd) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // rd_acc needs busy, so it never collides with the IDLE clear above.
      if (rd_acc) begin
        if (rd_keep) rd_count    <= rd_count + 1'b1;
        else         rd_overflow <= 1'b1;
      end
      if (to_fire) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc && rd_keep) capture[rd_count[RAW-1:0]] <= S_AXIS_RDATA_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rb_data <= '0;
    else     rb_data <= capture[rb_addr];
  end

`ifdef SDDT_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          any_xfer;

  assign any_xfer = cmd_xfer | wd_xfer | rd_acc;
  // Fires on the edge where the idle count would reach TIMEOUT_CYCLES.
  assign to_fire  = busy & ~any_xfer & (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (start_acc) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (busy) begin
      if (any_xfer)     to_cnt  <= '0;
      else if (to_fire) timeout <= 1'b1;
      else              to_cnt  <= to_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_xfer;
  assign unused_xfer = cmd_xfer | wd_xfer;
  assign to_fire     = 1'b0;
`endif

endmodule

// File: tb/tb_sddt_host_driver.sv
module tb_sddt_host_driver;
  localparam int CD = 64, WD = 16, RD = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_cmd_we;
  logic [5:0]   cfg_cmd_addr;
  logic [127:0] cfg_cmd_data;
  logic         cfg_wd_we;
  logic [3:0]   cfg_wd_addr;
  logic [511:0] cfg_wd_data;
  logic [6:0]   cfg_num_cmd;
  logic [4:0]   cfg_num_wdata;
  logic [4:0]   cfg_num_rdata;
  logic         start;
  logic         busy, done, rd_overflow;
  logic [4:0]   rd_count;
`ifdef SDDT_HOST_TIMEOUT_EN
  logic         timeout;
`endif
  logic [3:0]   rb_addr;
  logic [511:0] rb_data;
  logic [127:0] M_AXIS_CMD_tdata;
  logic         M_AXIS_CMD_tvalid, M_AXIS_CMD_tready;
  logic [511:0] M_AXIS_WDATA_tdata;
  logic         M_AXIS_WDATA_tvalid, M_AXIS_WDATA_tready;
  logic [511:0] S_AXIS_RDATA_tdata;
  logic [63:0]  S_AXIS_RDATA_tkeep;
  logic         S_AXIS_RDATA_tlast, S_AXIS_RDATA_tvalid, S_AXIS_RDATA_tready;

  always #5 clk = ~clk;

  sddt_host_driver #(.CMD_DEPTH(CD), .WDATA_DEPTH(WD), .RDATA_DEPTH(RD), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .cfg_cmd_we(cfg_cmd_we), .cfg_cmd_addr(cfg_cmd_addr), .cfg_cmd_data(cfg_cmd_data),
    .cfg_wd_we(cfg_wd_we), .cfg_wd_addr(cfg_wd_addr), .cfg_wd_data(cfg_wd_data),
    .cfg_num_cmd(cfg_num_cmd), .cfg_num_wdata(cfg_num_wdata), .cfg_num_rdata(cfg_num_rdata),
    .start(start), .busy(busy), .done(done), .rd_overflow(rd_overflow), .rd_count(rd_count),
`ifdef SDDT_HOST_TIMEOUT_EN
    .timeout(timeout),
`endif
    .rb_addr(rb_addr), .rb_data(rb_data),
    .M_AXIS_CMD_tdata(M_AXIS_CMD_tdata), .M_AXIS_CMD_tvalid(M_AXIS_CMD_tvalid),
    .M_AXIS_CMD_tready(M_AXIS_CMD_tready),
    .M_AXIS_WDATA_tdata(M_AXIS_WDATA_tdata), .M_AXIS_WDATA_tvalid(M_AXIS_WDATA_tvalid),
    .M_AXIS_WDATA_tready(M_AXIS_WDATA_tready),
    .S_AXIS_RDATA_tdata(S_AXIS_RDATA_tdata), .S_AXIS_RDATA_tkeep(S_AXIS_RDATA_tkeep),
    .S_AXIS_RDATA_tlast(S_AXIS_RDATA_tlast), .S_AXIS_RDATA_tvalid(S_AXIS_RDATA_tvalid),
    .S_AXIS_RDATA_tready(S_AXIS_RDATA_tready)
  );

  int checks = 0, errors = 0;

  // Reference model: buffer images, and the order in which beats must appear.
  logic [127:0] ref_cmd [CD];
  logic [511:0] ref_wd  [WD];
  logic [511:0] rsent [$];
  logic [127:0] cmd_got [$];
  int           cmd_cyc [$];
  logic [511:0] wd_got [$];
  int ncyc = 0, cmd_vld_cyc = 0, wd_vld_cyc = 0;
  logic cmd_hold = 1'b0, wd_hold = 1'b0;
  logic [127:0] cmd_held;
  logic [511:0] wd_held;
  int cmd_mode = 1, wd_mode = 1, tcyc = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Monitor: records transfers and checks AXIS hold-stable rule.
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      cmd_hold = 1'b0;
      wd_hold  = 1'b0;
    end else begin
      if (cmd_hold) begin
        chk("cmd_hold_valid", M_AXIS_CMD_tvalid, 1);
        chk("cmd_hold_data", M_AXIS_CMD_tdata, cmd_held);
      end
      if (wd_hold) begin
        chk("wd_hold_valid", M_AXIS_WDATA_tvalid, 1);
        chk("wd_hold_data", M_AXIS_WDATA_tdata, wd_held);
      end
      if (M_AXIS_CMD_tvalid) cmd_vld_cyc++;
      if (M_AXIS_WDATA_tvalid) wd_vld_cyc++;
      if (M_AXIS_CMD_tvalid && M_AXIS_CMD_tready) begin
        cmd_got.push_back(M_AXIS_CMD_tdata);
        cmd_cyc.push_back(ncyc);
      end
      if (M_AXIS_WDATA_tvalid && M_AXIS_WDATA_tready) wd_got.push_back(M_AXIS_WDATA_tdata);
      cmd_hold = M_AXIS_CMD_tvalid && !M_AXIS_CMD_tready;
      cmd_held = M_AXIS_CMD_tdata;
      wd_hold  = M_AXIS_WDATA_tvalid && !M_AXIS_WDATA_tready;
      wd_held  = M_AXIS_WDATA_tdata;
    end
  end

  // Modes: 0 low, 1 high, 2 toggle each cycle, 3 random.
  task automatic apply_ready();
    case (cmd_mode)
      0: M_AXIS_CMD_tready = 1'b0;
      1: M_AXIS_CMD_tready = 1'b1;
      2: M_AXIS_CMD_tready = ((tcyc & 1) == 1);
      default: M_AXIS_CMD_tready = 1'($urandom_range(0, 1));
    endcase
    case (wd_mode)
      0: M_AXIS_WDATA_tready = 1'b0;
      1: M_AXIS_WDATA_tready = 1'b1;
      2: M_AXIS_WDATA_tready = ((tcyc & 1) == 1);
      default: M_AXIS_WDATA_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
    apply_ready();
  endtask

  task automatic set_mode(input int c, input int w);
    cmd_mode = c;
    wd_mode  = w;
    apply_ready();
  endtask

  task automatic load_cmd(input int idx, input logic [127:0] v);
    cfg_cmd_we = 1'b1; cfg_cmd_addr = 6'(idx); cfg_cmd_data = v;
    tick();
    cfg_cmd_we = 1'b0;
    ref_cmd[idx] = v;
  endtask

  task automatic load_wd(input int idx, input logic [511:0] v);
    cfg_wd_we = 1'b1; cfg_wd_addr = 4'(idx); cfg_wd_data = v;
    tick();
    cfg_wd_we = 1'b0;
    ref_wd[idx] = v;
  endtask

  task automatic start_run(input int nc, input int nw, input int nr);
    cfg_num_cmd = 7'(nc); cfg_num_wdata = 5'(nw); cfg_num_rdata = 5'(nr);
    cmd_got.delete(); cmd_cyc.delete(); wd_got.delete(); rsent.delete();
    cmd_vld_cyc = 0; wd_vld_cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_rbeat(input logic [511:0] v);
    logic acc = 1'b0;
    int g = 0;
    S_AXIS_RDATA_tvalid = 1'b1;
    S_AXIS_RDATA_tdata  = v;
    while (!acc && g < 50) begin
      acc = S_AXIS_RDATA_tready;
      tick();
      g++;
    end
    S_AXIS_RDATA_tvalid = 1'b0;
    chk("rbeat_accepted", acc, 1);
    if (acc) rsent.push_back(v);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("run_done", done, 1);
  endtask

  // Compares everything a finished run produced against the model.
  task automatic check_run(input string nm, input int nc, input int nw, input int nr);
    int ec = (nc > CD) ? CD : nc;
    int ew = (nw > WD) ? WD : nw;
    int er = (nr > RD) ? RD : nr;
    int ecap = (rsent.size() < er) ? rsent.size() : er;
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_cmd_n"}, cmd_got.size(), ec);
    for (int i = 0; i < ec && i < cmd_got.size(); i++)
      chk($sformatf("%s_cmd%0d", nm, i), cmd_got[i], ref_cmd[i]);
    chk({nm, "_wd_n"}, wd_got.size(), ew);
    for (int i = 0; i < ew && i < wd_got.size(); i++)
      chk($sformatf("%s_wd%0d", nm, i), wd_got[i], ref_wd[i]);
    chk({nm, "_rd_count"}, rd_count, ecap);
    chk({nm, "_rd_overflow"}, rd_overflow, (rsent.size() > er) ? 1 : 0);
    for (int i = 0; i < ecap; i++) begin
      rb_addr = 4'(i);
      tick();
      chk($sformatf("%s_rb%0d", nm, i), rb_data, rsent[i]);
    end
  endtask

  initial begin
    logic [511:0] va, vb;
    int nc, nw, nr, nb;
    rst = 1'b1; start = 1'b0;
    cfg_cmd_we = 0; cfg_cmd_addr = 0; cfg_cmd_data = 0;
    cfg_wd_we = 0; cfg_wd_addr = 0; cfg_wd_data = 0;
    cfg_num_cmd = 0; cfg_num_wdata = 0; cfg_num_rdata = 0; rb_addr = 0;
    S_AXIS_RDATA_tdata = 0; S_AXIS_RDATA_tkeep = '1; S_AXIS_RDATA_tlast = 1'b1;
    S_AXIS_RDATA_tvalid = 1'b0;
    set_mode(1, 1);
    tick(); tick();

    // Reset state, sampled while reset is held.
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", rd_overflow, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_cmd_vld", M_AXIS_CMD_tvalid, 0);
    chk("rst_wd_vld", M_AXIS_WDATA_tvalid, 0);
    chk("rst_rd_rdy", S_AXIS_RDATA_tready, 0);
    chk("rst_rb_data", rb_data, 0);
    rst = 1'b0;
    tick();

    // Basic program: 4 cmds, 2 wdata beats, 2 read beats, full-rate ready.
    for (int i = 0; i < 4; i++) load_cmd(i, 128'(i + 1));
    load_wd(0, rnd512());
    load_wd(1, rnd512());
    va = rnd512(); vb = rnd512();
    start_run(4, 2, 2);
    send_rbeat(va);
    send_rbeat(vb);
    wait_done(100);
    check_run("basic", 4, 2, 2);
    for (int i = 1; i < 4 && i < cmd_cyc.size(); i++)
      chk($sformatf("basic_b2b%0d", i), cmd_cyc[i] - cmd_cyc[i-1], 1);

    // CMD backpressure toggling each cycle.
    set_mode(2, 1);
    start_run(4, 2, 2);
    send_rbeat(rnd512());
    send_rbeat(rnd512());
    wait_done(100);
    check_run("toggle", 4, 2, 2);

    // Read overflow: one expected, three returned while still in RUN.
    set_mode(1, 1);
    start_run(4, 2, 1);
    for (int i = 0; i < 3; i++) send_rbeat(rnd512());
    wait_done(100);
    check_run("ovf", 4, 2, 1);

    // All counts zero: done on the third edge after start.
    start_run(0, 0, 0);
    chk("zero_busy_e1", busy, 1);
    chk("zero_done_e1", done, 0);
    tick();
    chk("zero_busy_e2", busy, 1);
    chk("zero_done_e2", done, 0);
    tick();
    chk("zero_done_e3", done, 1);
    chk("zero_busy_e3", busy, 0);
    chk("zero_cmd_vld", cmd_vld_cyc, 0);
    chk("zero_wd_vld", wd_vld_cyc, 0);

    // Reset with CMD pointer at 2 of 4, then replay from entry 0.
    set_mode(1, 1);
    start_run(4, 0, 0);
    tick(); tick();
    set_mode(0, 1);
    chk("rstmid_sent", cmd_got.size(), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_cmd_vld", M_AXIS_CMD_tvalid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    set_mode(1, 1);
    start_run(4, 0, 0);
    wait_done(100);
    check_run("replay", 4, 0, 0);

    // Randomized runs with clamping, random backpressure and read traffic.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < CD; i++) load_cmd(i, {$urandom(), $urandom(), $urandom(), $urandom()});
      for (int i = 0; i < WD; i++) load_wd(i, rnd512());
      nc = $urandom_range(1, 127);
      nw = $urandom_range(0, 31);
      nr = $urandom_range(0, 31);
      nb = ((nr > RD) ? RD : nr) + $urandom_range(0, 2);
      set_mode(0, 3);  // hold CMD so all read beats land while in RUN
      start_run(nc, nw, nr);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_rbeat(rnd512());
      end
      set_mode(3, 3);
      wait_done(3000);
      check_run($sformatf("rnd%0d", it), nc, nw, nr);
    end

`ifdef SDDT_HOST_TIMEOUT_EN
    // Watchdog: no read beat returned; fires 100 cycles after last CMD beat.
    set_mode(1, 1);
    start_run(2, 0, 1);
    tick(); tick();
    chk("to_cmd_n", cmd_got.size(), 2);
    repeat (99) tick();
    chk("to_early_timeout", timeout, 0);
    chk("to_early_done", done, 0);
    tick();
    chk("to_timeout", timeout, 1);
    chk("to_done", done, 1);
    chk("to_busy", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sddt_host_driver.md
Name: sddt_host_driver

Overview:
- Host-side counterpart of the SDDT core's AXI-Stream interfaces, in the core's axi_aclk domain.
- Holds a preloaded program of 128-bit command words and 512-bit write-data beats, and streams them out on master CMD/WDATA streams after a start pulse.
- Captures returning 512-bit read-data beats into a local buffer for readback, and reports completion, counts and error flags.

Parameters:
- CMD_DEPTH, 64, command buffer entries (power of 2)
- WDATA_DEPTH, 16, write-data buffer entries (power of 2)
- RDATA_DEPTH, 16, read-data capture entries (power of 2)
- TIMEOUT_CYCLES, 65535, watchdog limit in clk cycles (used only with the optional feature)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_cmd_we  in  1  command buffer write strobe
- cfg_cmd_addr  in  $clog2(CMD_DEPTH)  command buffer write address
- cfg_cmd_data  in  128  command word
- cfg_wd_we  in  1  write-data buffer write strobe
- cfg_wd_addr  in  $clog2(WDATA_DEPTH)  write-data buffer write address
- cfg_wd_data  in  512  write-data beat
- cfg_num_cmd  in  $clog2(CMD_DEPTH)+1  commands to send
- cfg_num_wdata  in  $clog2(WDATA_DEPTH)+1  write beats to send
- cfg_num_rdata  in  $clog2(RDATA_DEPTH)+1  read beats expected
- start  in  1  one-cycle run request
- busy  out  1  run in progress
- done  out  1  sticky; set at run end, cleared by next accepted start
- rd_overflow  out  1  sticky; beat received beyond cfg_num_rdata
- rd_count  out  $clog2(RDATA_DEPTH)+1  read beats received this run
- rb_addr  in  $clog2(RDATA_DEPTH)  capture-buffer readback address
- rb_data  out  512  capture-buffer entry at rb_addr, registered, 1-cycle latency
- M_AXIS_CMD_tdata/tvalid/tready  out/out/in  128/1/1  command stream to core
- M_AXIS_WDATA_tdata/tvalid/tready  out/out/in  512/1/1  write-data stream to core
- S_AXIS_RDATA_tdata/tkeep/tlast/tvalid/tready  in/in/in/in/out  512/64/1/1/1  read-data stream from core

Behaviour:
- Reset values:
  - busy=0, done=0, rd_overflow=0, rd_count=0, all tvalid=0, S_AXIS_RDATA_tready=0, rb_data=0.
  - Buffer RAM contents are not cleared.
- Reset mid-run: state returns to IDLE on the next edge; tvalid drops even if a beat was not accepted. That beat is lost by design.
- FSM: IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: start=1 latches the three counts, clamped to their DEPTH, and clears done, rd_overflow, rd_count and all pointers. Next state RUN.
  - RUN: CMD and WDATA senders run independently. When both have sent their latched counts, go to DRAIN (same cycle as the last accepted beat + 1).
  - DRAIN: when rd_count >= latched cfg_num_rdata, set done=1 and go to IDLE. This can happen on the first DRAIN cycle.
- busy=1 in RUN and DRAIN.
- start while busy is ignored. cfg_*_we while busy is ignored; buffers stay stable during a run.
- Sender rules, identical for CMD and WDATA:
  - tvalid=1 while pointer < count. tdata = buffer[pointer].
  - Transfer occurs when tvalid & tready; the pointer increments the same edge.
  - Once tvalid is asserted, tvalid and tdata stay stable until the transfer.
  - Sustains 1 beat/cycle with tready held high: no bubbles between entries.
  - A count of 0 means the stream never asserts tvalid.
- Receiver rules:
  - S_AXIS_RDATA_tready=1 whenever busy, 0 in IDLE.
  - Accepted beat with rd_count < latched cfg_num_rdata and rd_count < RDATA_DEPTH: written to capture[rd_count], and rd_count increments.
  - Otherwise the beat is accepted, dropped, and rd_overflow is set; rd_count saturates.
  - tkeep and tlast are ignored. The core sends all-ones and 1.
- Read data may arrive while CMD/WDATA are still sending; it is captured in RUN as well as DRAIN.
- All counts zero: start -> RUN (1 cycle) -> DRAIN (1 cycle) -> done=1, busy=0 three cycles after start.
- rb_data is readable at any time, including mid-run; it returns the last written value.

Optional Feature:
- Macro: SDDT_HOST_TIMEOUT_EN.
- Defined:
  - Adds output `timeout` (1, sticky, reset 0, cleared by accepted start).
  - A cycle counter resets on entry to RUN and on every accepted beat on any of the three streams.
  - If it reaches TIMEOUT_CYCLES while busy: timeout=1, done=1, state goes to IDLE, tvalids drop.
- Not defined: no timeout port and no counter; a run waits indefinitely.

Test Plan:
- Load 4 cmds (0x1..0x4) and 2 wdata beats; counts 4/2/2; tready=1; core returns 2 beats A,B -> CMD beats 1,2,3,4 on consecutive cycles, WDATA 2 beats, rd_count=2, rb_addr 0/1 reads A/B, done=1, busy=0.
- Same program, CMD tready toggled 1/0 every cycle -> each word held stable while tready=0, no word duplicated or skipped, 4 transfers total.
- cfg_num_rdata=1, 3 read beats returned -> rd_count=1, rd_overflow=1, capture[0]=first beat only.
- All counts 0, start -> no tvalid ever, done=1 on the third edge after start.
- rst asserted while CMD pointer=2 of 4 -> next edge tvalid=0, busy=0, done=0; new start replays from entry 0.
- With SDDT_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=100, cfg_num_rdata=1, no read beat returned -> timeout=1 and done=1 100 cycles after the last CMD beat.
